// File: rtl/bomb_slot_arbiter.sv
// Bomb slot pool shared by two players. Each cycle it arbitrates the two
// players' bomb requests round-robin, counts down the fuses and reports
// one expired bomb per cycle downstream.
//
// Handshake: req0/req1 are one-cycle pulses sampled at the clock edge; each
// request gets exactly one grant or reject pulse, registered one cycle later.
// explodeValid is a one-cycle pulse with no back-pressure. Each explosion
// event is emitted exactly once, and explodeX/Y/Owner are only meaningful
// while explodeValid is high.
module bomb_slot_arbiter #(
  parameter int NUM_SLOTS      = 4,
  parameter int MAX_PER_PLAYER = 2,
  parameter int FUSE_TICKS     = 8,
  parameter int FUSE_W         = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   stunned0,
  input  logic                   stunned1,
  input  logic [5:0]             posX0,
  input  logic [5:0]             posY0,
  input  logic [5:0]             posX1,
  input  logic [5:0]             posY1,
  output logic                   grant0,
  output logic                   grant1,
  output logic                   reject0,
  output logic                   reject1,
  output logic                   explodeValid,
  output logic [5:0]             explodeX,
  output logic [5:0]             explodeY,
  output logic                   explodeOwner,
  output logic [1:0]             live0,
  output logic [1:0]             live1,
  output logic [2*NUM_SLOTS-1:0] slot_states
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CW = $clog2(NUM_SLOTS + 1);

  typedef enum logic [1:0] {FREE = 2'd0, ARMED = 2'd1, PENDING = 2'd2} slot_state_e;

  slot_state_e       state_q [NUM_SLOTS];
  logic              own_q   [NUM_SLOTS];
  logic [5:0]        x_q     [NUM_SLOTS];
  logic [5:0]        y_q     [NUM_SLOTS];
  logic [FUSE_W-1:0] fuse_q  [NUM_SLOTS];
  logic              ptr_q;

  logic [CW-1:0] cnt      [2];
  logic [CW-1:0] cnt_next [2];
  logic [1:0]    req_v;
  logic [1:0]    stun_v;
  logic [5:0]    px [2];
  logic [5:0]    py [2];
  logic          first;
  logic          second;
  logic          f_free, f_clash, f_ok;
  logic          s_free, s_clash, s_ok;
  logic [SW-1:0] f_slot, s_slot;
  logic          p_found;
  logic [SW-1:0] p_slot;
  logic          g0, g1, d0, d1;

  // Expose every slot's state for observation.
  always_comb begin
    slot_states = '0;
    for (int s = 0; s < NUM_SLOTS; s++) slot_states[2*s +: 2] = state_q[s];
  end

  // Live slot count per player (ARMED and PENDING both count).
  always_comb begin
    cnt[0] = '0;
    cnt[1] = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (state_q[s] != FREE) begin
        if (own_q[s]) cnt[1] = cnt[1] + CW'(1);
        else          cnt[0] = cnt[0] + CW'(1);
      end
    end
  end

  // Evaluate the priority requester first, then the other against the updated pool.
  always_comb begin
    req_v   = {req1, req0};
    stun_v  = {stunned1, stunned0};
    px[0]   = posX0;
    py[0]   = posY0;
    px[1]   = posX1;
    py[1]   = posY1;
    first   = (req0 && req1) ? ptr_q : req1;
    second  = ~first;
    f_free  = 1'b0;
    f_slot  = '0;
    f_clash = 1'b0;
    s_clash = 1'b0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!f_free && state_q[s] == FREE) begin
        f_free = 1'b1;
        f_slot = SW'(s);
      end
      if (state_q[s] != FREE && x_q[s] == px[first] && y_q[s] == py[first]) f_clash = 1'b1;
      if (state_q[s] != FREE && x_q[s] == px[second] && y_q[s] == py[second]) s_clash = 1'b1;
    end
    f_ok = req_v[first] && !stun_v[first] && (cnt[first] < CW'(MAX_PER_PLAYER)) &&
           !f_clash && f_free;
    // The priority player's new bomb already occupies its cell.
    if (f_ok && px[first] == px[second] && py[first] == py[second]) s_clash = 1'b1;
    s_free = 1'b0;
    s_slot = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!s_free && state_q[s] == FREE && !(f_ok && f_slot == SW'(s))) begin
        s_free = 1'b1;
        s_slot = SW'(s);
      end
    end
    s_ok = req_v[second] && !stun_v[second] && (cnt[second] < CW'(MAX_PER_PLAYER)) &&
           !s_clash && s_free;
  end

  // Pick the lowest-index expired slot and derive next-cycle live counts.
  always_comb begin
    p_found = 1'b0;
    p_slot  = '0;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (!p_found && state_q[s] == PENDING) begin
        p_found = 1'b1;
        p_slot  = SW'(s);
      end
    end
    g0 = (f_ok && !first) || (s_ok && !second);
    g1 = (f_ok && first) || (s_ok && second);
    d0 = p_found && !own_q[p_slot];
    d1 = p_found && own_q[p_slot];
    cnt_next[0] = cnt[0] + CW'(g0) - CW'(d0);
    cnt_next[1] = cnt[1] + CW'(g1) - CW'(d1);
  end

  // Slot pool, fuse countdown, explosion reporting and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        state_q[s] <= FREE;
        own_q[s]   <= 1'b0;
        x_q[s]     <= '0;
        y_q[s]     <= '0;
        fuse_q[s]  <= '0;
      end
      ptr_q        <= 1'b0;
      grant0       <= 1'b0;
      grant1       <= 1'b0;
      reject0      <= 1'b0;
      reject1      <= 1'b0;
      explodeValid <= 1'b0;
      explodeX     <= '0;
      explodeY     <= '0;
      explodeOwner <= 1'b0;
      live0        <= '0;
      live1        <= '0;
    end else begin
      // Only slots already armed see the tick; newly allocated ones were FREE.
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (tick && state_q[s] == ARMED) begin
          if (fuse_q[s] > FUSE_W'(1)) fuse_q[s] <= fuse_q[s] - FUSE_W'(1);
          else                        state_q[s] <= PENDING;
        end
      end
      if (p_found) state_q[p_slot] <= FREE;
      if (f_ok) begin
        state_q[f_slot] <= ARMED;
        fuse_q[f_slot]  <= FUSE_W'(FUSE_TICKS);
        own_q[f_slot]   <= first;
        x_q[f_slot]     <= px[first];
        y_q[f_slot]     <= py[first];
      end
      if (s_ok) begin
        state_q[s_slot] <= ARMED;
        fuse_q[s_slot]  <= FUSE_W'(FUSE_TICKS);
        own_q[s_slot]   <= second;
        x_q[s_slot]     <= px[second];
        y_q[s_slot]     <= py[second];
      end
      if (req0 && req1) ptr_q <= ~ptr_q;
      grant0       <= g0;
      grant1       <= g1;
      reject0      <= req0 && !g0;
      reject1      <= req1 && !g1;
      explodeValid <= p_found;
      explodeX     <= p_found ? x_q[p_slot] : 6'd0;
      explodeY     <= p_found ? y_q[p_slot] : 6'd0;
      explodeOwner <= p_found && own_q[p_slot];
      live0        <= cnt_next[0][1:0];
      live1        <= cnt_next[1][1:0];
    end
  end

endmodule

// File: tb/tb_bomb_slot_arbiter.sv
// Testbench for bomb_slot_arbiter: directed scenarios plus a random soak,
// all checked cycle by cycle against a list-of-bombs reference model.
module tb_bomb_slot_arbiter;

  localparam int NS   = 4;
  localparam int MAXP = 2;
  localparam int FUSE = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic       stunned0 = 1'b0;
  logic       stunned1 = 1'b0;
  logic [5:0] posX0 = '0;
  logic [5:0] posY0 = '0;
  logic [5:0] posX1 = '0;
  logic [5:0] posY1 = '0;
  logic       grant0, grant1, reject0, reject1;
  logic       explodeValid, explodeOwner;
  logic [5:0] explodeX, explodeY;
  logic [1:0] live0, live1;
  logic [2*NS-1:0] slot_states;

  int tests  = 0;
  int failed = 0;

  // Scoreboard: one expected output vector per clock cycle.
  logic [21:0] exp_q[$];

  // Reference model: bombs as plain records (0 free, 1 armed, 2 pending).
  int m_state[NS];
  int m_own[NS];
  int m_x[NS];
  int m_y[NS];
  int m_fuse[NS];
  int m_ptr;

  bomb_slot_arbiter #(
    .NUM_SLOTS(NS), .MAX_PER_PLAYER(MAXP), .FUSE_TICKS(FUSE), .FUSE_W(4)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .req0(req0), .req1(req1), .stunned0(stunned0), .stunned1(stunned1),
    .posX0(posX0), .posY0(posY0), .posX1(posX1), .posY1(posY1),
    .grant0(grant0), .grant1(grant1), .reject0(reject0), .reject1(reject1),
    .explodeValid(explodeValid), .explodeX(explodeX), .explodeY(explodeY),
    .explodeOwner(explodeOwner), .live0(live0), .live1(live1),
    .slot_states(slot_states)
  );

  // Clock.
  always #5 clock = ~clock;

  function automatic logic [21:0] dut_vec();
    return {grant0, grant1, reject0, reject1, explodeValid, explodeX, explodeY,
            explodeOwner, live0, live1};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    int lv[2];
    int rq[2];
    int st[2];
    int px[2];
    int py[2];
    int g[2];
    int al_slot[2];
    int al_own[2];
    int first, p, ok, slot, sel, tx, ty;
    logic [21:0] v;
    if (reset === 1'b0) begin
      for (int s = 0; s < NS; s++) begin
        m_state[s] = 0; m_own[s] = 0; m_x[s] = 0; m_y[s] = 0; m_fuse[s] = 0;
      end
      m_ptr = 0;
      exp_q.push_back(22'd0);
      return;
    end
    rq[0] = int'(req0); rq[1] = int'(req1);
    st[0] = int'(stunned0); st[1] = int'(stunned1);
    px[0] = int'(posX0); py[0] = int'(posY0);
    px[1] = int'(posX1); py[1] = int'(posY1);
    lv[0] = 0; lv[1] = 0;
    for (int s = 0; s < NS; s++) if (m_state[s] != 0) lv[m_own[s]]++;
    g[0] = 0; g[1] = 0;
    al_slot[0] = -1; al_slot[1] = -1; al_own[0] = 0; al_own[1] = 0;
    tx = -1; ty = -1;
    first = (rq[0] != 0 && rq[1] != 0) ? m_ptr : rq[1];
    for (int k = 0; k < 2; k++) begin
      p = (k == 0) ? first : 1 - first;
      if (rq[p] == 0) continue;
      ok = (st[p] == 0 && lv[p] < MAXP) ? 1 : 0;
      for (int s = 0; s < NS; s++)
        if (m_state[s] != 0 && m_x[s] == px[p] && m_y[s] == py[p]) ok = 0;
      if (al_slot[0] >= 0 && tx == px[p] && ty == py[p]) ok = 0;
      slot = -1;
      for (int s = 0; s < NS; s++)
        if (slot < 0 && m_state[s] == 0 && s != al_slot[0]) slot = s;
      if (slot < 0) ok = 0;
      if (ok != 0) begin
        g[p] = 1; al_slot[k] = slot; al_own[k] = p; tx = px[p]; ty = py[p];
      end
    end
    sel = -1;
    for (int s = 0; s < NS; s++) if (sel < 0 && m_state[s] == 2) sel = s;
    v = '0;
    v[21] = (g[0] != 0);
    v[20] = (g[1] != 0);
    v[19] = (rq[0] != 0 && g[0] == 0);
    v[18] = (rq[1] != 0 && g[1] == 0);
    if (sel >= 0) begin
      v[17]    = 1'b1;
      v[16:11] = 6'(m_x[sel]);
      v[10:5]  = 6'(m_y[sel]);
      v[4]     = (m_own[sel] != 0);
    end
    if (tick) begin
      for (int s = 0; s < NS; s++)
        if (m_state[s] == 1) begin
          if (m_fuse[s] > 1) m_fuse[s]--;
          else m_state[s] = 2;
        end
    end
    if (sel >= 0) m_state[sel] = 0;
    for (int k = 0; k < 2; k++)
      if (al_slot[k] >= 0) begin
        m_state[al_slot[k]] = 1;
        m_fuse[al_slot[k]]  = FUSE;
        m_own[al_slot[k]]   = al_own[k];
        m_x[al_slot[k]]     = px[al_own[k]];
        m_y[al_slot[k]]     = py[al_own[k]];
      end
    if (rq[0] != 0 && rq[1] != 0) m_ptr = 1 - m_ptr;
    lv[0] = 0; lv[1] = 0;
    for (int s = 0; s < NS; s++) if (m_state[s] != 0) lv[m_own[s]]++;
    v[3:2] = 2'(lv[0]);
    v[1:0] = 2'(lv[1]);
    exp_q.push_back(v);
  endtask

  // Driver: update the model, clock the DUT, settle past the edge.
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; tick = 0; stunned0 = 0; stunned1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [21:0] e;
    reset = 0; req0 = 1; posX0 = 6'd1; posY0 = 6'd1;
    for (int i = 0; i < 2; i++) begin
      step();
      e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin
        failed++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, dut_vec(), e);
      end
    end
    tests++;
    if ({grant0, reject0, explodeValid, live0, live1} !== 7'd0) begin
      failed++; $display("FAIL reset_outputs got=%b exp=0", {grant0, reject0, explodeValid, live0, live1});
    end
    reset = 1; req0 = 0;
    step();
    e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin
      failed++; $display("FAIL reset_release got=%h exp=%h", dut_vec(), e);
    end
    tests++;
    if ({grant0, live0, live1} !== 5'd0) begin
      failed++; $display("FAIL reset_after got=%b exp=0", {grant0, live0, live1});
    end
  endtask

  task automatic test_single_bomb();
    logic [21:0] e;
    do_reset();
    req0 = 1; posX0 = 6'd3; posY0 = 6'd4;
    step();
    e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin
      failed++; $display("FAIL single_req got=%h exp=%h", dut_vec(), e);
    end
    tests++;
    if (grant0 !== 1'b1 || live0 !== 2'd1) begin
      failed++; $display("FAIL single_grant got=%b/%0d exp=1/1", grant0, live0);
    end
    req0 = 0;
    for (int i = 0; i < 3 * FUSE; i++) begin
      tick = ((i % 3) == 2);
      step();
      e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin
        failed++; $display("FAIL single_fuse cyc=%0d got=%h exp=%h", i, dut_vec(), e);
      end
    end
    tick = 0;
    tests++;
    if (explodeValid !== 1'b0 || live0 !== 2'd1) begin
      failed++; $display("FAIL single_pending got=%b/%0d exp=0/1", explodeValid, live0);
    end
    step();
    e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin
      failed++; $display("FAIL single_explode got=%h exp=%h", dut_vec(), e);
    end
    tests++;
    if ({explodeValid, explodeX, explodeY, explodeOwner, live0} !== {1'b1, 6'd3, 6'd4, 1'b0, 2'd0}) begin
      failed++; $display("FAIL single_event got=%b,%0d,%0d,%b,%0d exp=1,3,4,0,0",
                         explodeValid, explodeX, explodeY, explodeOwner, live0);
    end
  endtask

  task automatic test_simultaneous();
    logic [21:0] e;
    do_reset();
    req0 = 1; req1 = 1; posX0 = 6'd5; posY0 = 6'd5; posX1 = 6'd5; posY1 = 6'd5;
    step();
    e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin
      failed++; $display("FAIL simul_same got=%h exp=%h", dut_vec(), e);
    end
    tests++;
    if ({grant0, grant1, reject0, reject1} !== 4'b1001) begin
      failed++; $display("FAIL simul_same_flags got=%b exp=1001", {grant0, grant1, reject0, reject1});
    end
    req0 = 1; req1 = 1; posX0 = 6'd5; posY0 = 6'd6; posX1 = 6'd7; posY1 = 6'd7;
    step();
    e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin
      failed++; $display("FAIL simul_diff got=%h exp=%h", dut_vec(), e);
    end
    tests++;
    if ({grant0, grant1, reject0, reject1} !== 4'b1100) begin
      failed++; $display("FAIL simul_diff_flags got=%b exp=1100", {grant0, grant1, reject0, reject1});
    end
    idle_inputs();
  endtask

  task automatic test_limit_and_stun();
    logic [21:0] e;
    logic [3:0] want[4];
    want[0] = 4'b1000; want[1] = 4'b1000; want[2] = 4'b0010; want[3] = 4'b0001;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      req0 = (i < 3); posX0 = 6'(i + 1); posY0 = 6'(i + 1);
      req1 = (i == 3); stunned1 = (i == 3); posX1 = 6'd9; posY1 = 6'd9;
      step();
      e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin
        failed++; $display("FAIL limit cyc=%0d got=%h exp=%h", i, dut_vec(), e);
      end
      tests++;
      if ({grant0, grant1, reject0, reject1} !== want[i]) begin
        failed++; $display("FAIL limit_flags cyc=%0d got=%b exp=%b", i, {grant0, grant1, reject0, reject1}, want[i]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [21:0] e;
    int ex[4] = '{1, 3, 7, 5};
    int ey[4] = '{2, 4, 8, 6};
    int eo[4] = '{0, 1, 1, 0};
    do_reset();
    req0 = 1; req1 = 1; posX0 = 6'd1; posY0 = 6'd2; posX1 = 6'd3; posY1 = 6'd4;
    step(); e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin failed++; $display("FAIL b2b_req1 got=%h exp=%h", dut_vec(), e); end
    posX0 = 6'd5; posY0 = 6'd6; posX1 = 6'd7; posY1 = 6'd8;
    step(); e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin failed++; $display("FAIL b2b_req2 got=%h exp=%h", dut_vec(), e); end
    req0 = 0; req1 = 0; tick = 1;
    for (int i = 0; i < FUSE; i++) begin
      step(); e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin failed++; $display("FAIL b2b_tick cyc=%0d got=%h exp=%h", i, dut_vec(), e); end
    end
    tick = 0;
    for (int i = 0; i < 4; i++) begin
      step(); e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin failed++; $display("FAIL b2b_drain cyc=%0d got=%h exp=%h", i, dut_vec(), e); end
      tests++;
      if (explodeValid !== 1'b1 || explodeX !== 6'(ex[i]) || explodeY !== 6'(ey[i]) ||
          explodeOwner !== 1'(eo[i])) begin
        failed++; $display("FAIL b2b_event cyc=%0d got=%b,%0d,%0d,%b exp=1,%0d,%0d,%0d",
                           i, explodeValid, explodeX, explodeY, explodeOwner, ex[i], ey[i], eo[i]);
      end
    end
    step(); e = exp_q.pop_front(); tests++;
    if (explodeValid !== 1'b0 || dut_vec() !== e) begin
      failed++; $display("FAIL b2b_quiet got=%h exp=%h", dut_vec(), e);
    end
  endtask

  task automatic test_full_pool();
    logic [21:0] e;
    do_reset();
    req0 = 1; req1 = 1; posX0 = 6'd1; posY0 = 6'd1; posX1 = 6'd9; posY1 = 6'd9;
    step(); e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin failed++; $display("FAIL full_fill1 got=%h exp=%h", dut_vec(), e); end
    req0 = 0; req1 = 0; tick = 1;
    step(); e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin failed++; $display("FAIL full_tick got=%h exp=%h", dut_vec(), e); end
    tick = 0; req0 = 1; req1 = 1; posX0 = 6'd2; posY0 = 6'd2; posX1 = 6'd10; posY1 = 6'd10;
    step(); e = exp_q.pop_front(); tests++;
    if (dut_vec() !== e) begin failed++; $display("FAIL full_fill2 got=%h exp=%h", dut_vec(), e); end
    req0 = 0; req1 = 0; tick = 1;
    for (int i = 0; i < FUSE - 1; i++) begin
      step(); e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin failed++; $display("FAIL full_ticks cyc=%0d got=%h exp=%h", i, dut_vec(), e); end
    end
    tick = 0; req0 = 1; posX0 = 6'd4; posY0 = 6'd4;
    for (int i = 0; i < 2; i++) begin
      step(); e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin failed++; $display("FAIL full_req cyc=%0d got=%h exp=%h", i, dut_vec(), e); end
      tests++;
      if ({grant0, reject0} !== ((i == 0) ? 2'b01 : 2'b10)) begin
        failed++; $display("FAIL full_flags cyc=%0d got=%b exp=%b", i, {grant0, reject0}, (i == 0) ? 2'b01 : 2'b10);
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [21:0] e;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset    = ($urandom_range(0, 99) != 0);
      tick     = ($urandom_range(0, 2) == 0);
      req0     = ($urandom_range(0, 2) == 0);
      req1     = ($urandom_range(0, 2) == 0);
      stunned0 = ($urandom_range(0, 7) == 0);
      stunned1 = ($urandom_range(0, 7) == 0);
      posX0    = 6'($urandom_range(0, 3));
      posY0    = 6'($urandom_range(0, 3));
      posX1    = 6'($urandom_range(0, 3));
      posY1    = 6'($urandom_range(0, 3));
      step(); e = exp_q.pop_front(); tests++;
      if (dut_vec() !== e) begin
        failed++; $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_vec(), e);
      end
    end
    reset = 1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_bomb();
    test_simultaneous();
    test_limit_and_stun();
    test_back_to_back();
    test_full_pool();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/bomb_slot_arbiter.md
Name: bomb_slot_arbiter

Overview:
- Shares a fixed pool of bomb slots between the two player FSMs.
- Accepts one-cycle bomb requests at each player's current grid position and arbitrates simultaneous requests round-robin.
- Runs a fuse countdown per slot and emits one explosion event per cycle to the downstream blast/stun detector and renderer.

Parameters:
- NUM_SLOTS, 4, total bomb slots shared by both players (2..8).
- MAX_PER_PLAYER, 2, maximum live slots one player may own.
- FUSE_TICKS, 8, fuse length in tick pulses (>=1).
- FUSE_W, 4, fuse counter width; must hold FUSE_TICKS.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- tick  in  1  one-cycle fuse timebase pulse from rate divider
- req0, req1  in  1  one-cycle bomb request, player 0/1 (bombRequested)
- stunned0, stunned1  in  1  player currently stunned
- posX0, posY0, posX1, posY1  in  6 each  requesting player's grid position
- grant0, grant1  out  1  request accepted (pulse)
- reject0, reject1  out  1  request refused (pulse)
- explodeValid  out  1  explosion event valid (pulse)
- explodeX, explodeY  out  6 each  exploding bomb position
- explodeOwner  out  1  owner of exploding bomb
- live0, live1  out  2  slots currently owned by player 0/1 (active or pending)

Behaviour:
- Reset: all outputs 0 and all slots free. The round-robin priority pointer resets to player 0.
- Reset mid-operation discards all live and pending bombs; no explosion event is emitted for them.
- Per-slot state: FREE, ARMED, PENDING, plus owner, x, y and fuse.
- Requests are sampled at the clock edge. grant/reject are registered and assert exactly 1 cycle after the req cycle, for 1 cycle.
- Every req produces exactly one grant or reject.
- A request is rejected if any of these hold:
  - the requester is stunned in the req cycle;
  - the requester's live count is >= MAX_PER_PLAYER;
  - any ARMED or PENDING slot holds the same (x,y);
  - no FREE slot exists.
- Simultaneous req0 and req1:
  - The priority player is evaluated first and takes the lowest-index FREE slot.
  - The other player is then evaluated against the updated state: the next FREE slot, its own limit, and position-clash with the priority player's new bomb. If both stand on the same cell, the non-priority player is rejected.
  - The priority pointer toggles after every cycle in which both req0 and req1 are high, whatever the outcome.
- Allocation: the slot becomes ARMED with fuse=FUSE_TICKS, owner and position latched.
- A slot allocated in a cycle is not decremented by a tick in that same cycle.
- Tick handling, for each ARMED slot:
  - fuse>1: fuse decrements by 1;
  - fuse==1: the slot goes to PENDING.
- Explosion reporting:
  - Each cycle, if any slot is PENDING, the lowest-index PENDING slot is reported. explodeValid/X/Y/Owner are registered and valid the cycle after selection; that slot returns to FREE.
  - Multiple PENDING slots are reported in consecutive cycles in index order.
  - PENDING slots still block their cell and count in live0/live1 until reported.
- A slot freed in cycle N is not allocatable by a request sampled in cycle N; it becomes available from cycle N+1.
- live0/live1 are registered counts, updated in the cycle after allocation or free; range 0..MAX_PER_PLAYER.
- Position is compared on the full 6-bit X and Y, with no clamping. Fuse arithmetic never wraps below 0.

Test Plan:
- Reset low 2 cycles with req0 high -> all outputs 0; after release, live0=live1=0 and no grant.
- req0 at (3,4), then 8 ticks spaced 3 cycles apart -> grant0 1 cycle after req. explodeValid with X=3, Y=4, owner=0 one cycle after the state goes PENDING following the 8th tick. live0 goes 1 then 0.
- req0 and req1 same cycle at (5,5) and (5,5), pointer=0 -> grant0, reject1. Repeat at (5,6)/(7,7) -> grant1 granted first (pointer toggled), grant0 also granted on a free slot.
- Player 0 places 3 bombs at distinct cells, MAX_PER_PLAYER=2 -> grant, grant, reject0. Then stunned1=1 with req1 -> reject1.
- Four bombs placed in one cycle pair, all expire on the same tick -> explodeValid asserted on 4 consecutive cycles, slots in ascending index order, matching positions and owners.
- Fill all 4 slots; request on the same cycle the first expired slot is reported -> reject. An identical request next cycle -> grant into the freed slot.
